instruction_decode: RTL and testbench

- Decode/execute/memory slice of the single-cycle MIPS-subset core.
- Splits a 32-bit instruction into fields and generates control signals (combinational).
- Drives an embedded ALU and a word-addressed data memory with synchronous write.
- Produces the register-file write-back value and destination register index; the PC, fetch and register file live outside this block.

---
 rtl/instruction_decode_pkg.sv | 49 ++++
 rtl/instruction_decode_alu.sv | 33 +++
 rtl/instruction_decode_data_memory.sv | 35 +++
 rtl/instruction_decode.sv | 116 +++++++++++
 tb/tb_instruction_decode.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_decode_pkg.sv
// Shared encodings for the decode/execute/memory slice: opcodes, R-type functs
// and the 4-bit ALU operation code.
package instruction_decode_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;
   localparam logic [3:0] ALU_LUI  = 4'd11;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/instruction_decode_alu.sv
// 32-bit combinational ALU; shifts move b by a[4:0], unused codes yield 0.
module alu
   import instruction_decode_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  alu_op,
   output logic [31:0] result,
   output logic        zero
);

   always_comb begin
      result = '0;
      case (alu_op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_NOR:  result = ~(a | b);
         ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: result = {31'b0, a < b};
         ALU_SLL:  result = b << a[4:0];
         ALU_SRL:  result = b >> a[4:0];
         ALU_SRA:  result = $unsigned($signed(b) >>> a[4:0]);
         ALU_LUI:  result = {b[15:0], 16'b0};
         default:  result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/instruction_decode_data_memory.sv
// Word-addressed data memory: asynchronous read, synchronous write, and a
// synchronous reset that clears every word and blocks the same-cycle write.
module data_memory #(
   parameter int MEM_DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data
);

   localparam int AW = $clog2(MEM_DEPTH);

   logic [31:0]   mem [MEM_DEPTH];
   logic [AW-1:0] idx;

   // Byte address: low two bits and anything above the array span are dropped.
   assign idx = addr[AW+1:2];

   logic unused_addr;
   assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else if (mem_write) begin
         mem[idx] <= write_data;
      end
   end

   assign read_data = mem[idx];

endmodule

// File: rtl/instruction_decode.sv
// Decode/execute/memory slice of the single-cycle core: field split, control
// decode, ALU operand selection, data memory and write-back mux.
module instruction_decode
   import instruction_decode_pkg::*;
#(
   parameter int MEM_DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction,
   input  logic [31:0] reg_rs,
   input  logic [31:0] reg_rt,
   output logic [5:0]  opcode,
   output logic [25:0] adr,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] imm,
   output logic        regwrite,
   output logic        memwrite,
   output logic        memread,
   output logic [3:0]  aluOp,
   output logic        immReg,
   output logic [4:0]  wr_reg,
   output logic [31:0] alu_result,
   output logic        zero,
   output logic [31:0] mem_rdata,
   output logic [31:0] write_data
);

   logic [31:0] imm_sext;
   logic [31:0] alu_a;
   logic [31:0] alu_b;

   assign opcode = instruction[31:26];
   assign adr    = instruction[25:0];
   assign rs     = instruction[25:21];
   assign rt     = instruction[20:16];
   assign rd     = instruction[15:11];
   assign shamt  = instruction[10:6];
   assign funct  = instruction[5:0];
   assign imm    = instruction[15:0];

   // Unknown opcodes and functs fall through to the all-disabled ADD defaults.
   always_comb begin
      regwrite = 1'b0;
      memwrite = 1'b0;
      memread  = 1'b0;
      immReg   = 1'b0;
      aluOp    = ALU_ADD;
      case (opcode)
         OP_RTYPE: begin
            regwrite = 1'b1;
            case (funct)
               F_SLL:          aluOp = ALU_SLL;
               F_SRL:          aluOp = ALU_SRL;
               F_SRA:          aluOp = ALU_SRA;
               F_ADD, F_ADDU:  aluOp = ALU_ADD;
               F_SUB, F_SUBU:  aluOp = ALU_SUB;
               F_AND:          aluOp = ALU_AND;
               F_OR:           aluOp = ALU_OR;
               F_XOR:          aluOp = ALU_XOR;
               F_NOR:          aluOp = ALU_NOR;
               F_SLT:          aluOp = ALU_SLT;
               F_SLTU:         aluOp = ALU_SLTU;
               default:        regwrite = 1'b0;
            endcase
         end
         OP_BEQ:   aluOp = ALU_SUB;
         OP_ADDI, OP_ADDIU: begin regwrite = 1'b1; immReg = 1'b1; aluOp = ALU_ADD;  end
         OP_SLTI:  begin regwrite = 1'b1; immReg = 1'b1; aluOp = ALU_SLT;  end
         OP_SLTIU: begin regwrite = 1'b1; immReg = 1'b1; aluOp = ALU_SLTU; end
         OP_ANDI:  begin regwrite = 1'b1; immReg = 1'b1; aluOp = ALU_AND;  end
         OP_ORI:   begin regwrite = 1'b1; immReg = 1'b1; aluOp = ALU_OR;   end
         OP_XORI:  begin regwrite = 1'b1; immReg = 1'b1; aluOp = ALU_XOR;  end
         OP_LUI:   begin regwrite = 1'b1; immReg = 1'b1; aluOp = ALU_LUI;  end
         OP_LW: begin
            regwrite = 1'b1;
            immReg   = 1'b1;
            memread  = 1'b1;
         end
         OP_SW: begin
            immReg   = 1'b1;
            memwrite = 1'b1;
         end
         default: ;
      endcase
   end

   assign imm_sext = {{16{imm[15]}}, imm};
   assign alu_a    = is_shift(aluOp) ? {27'b0, shamt} : reg_rs;
   assign alu_b    = immReg ? imm_sext : reg_rt;
   assign wr_reg   = immReg ? rt : rd;

   alu u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .alu_op (aluOp),
      .result (alu_result),
      .zero   (zero)
   );

   data_memory #(.MEM_DEPTH(MEM_DEPTH)) u_data_memory (
      .clk        (clk),
      .rst        (rst),
      .mem_write  (memwrite),
      .addr       (alu_result),
      .write_data (reg_rt),
      .read_data  (mem_rdata)
   );

   assign write_data = memread ? mem_rdata : alu_result;

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench: directed cases plus random instructions compared to a
// behavioural model of the instruction set and a shadow copy of the memory.
module tb_instruction_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instruction;
   logic [31:0] reg_rs;
   logic [31:0] reg_rt;
   logic [5:0]  opcode;
   logic [25:0] adr;
   logic [4:0]  rs, rt, rd, shamt;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic        regwrite, memwrite, memread, immReg, zero;
   logic [3:0]  aluOp;
   logic [4:0]  wr_reg;
   logic [31:0] alu_result, mem_rdata, write_data;

   int total = 0;
   int bad   = 0;

   logic [31:0] mdl_mem [256];

   typedef struct packed {
      logic        regwrite;
      logic        memwrite;
      logic        memread;
      logic        immreg;
      logic [3:0]  aluop;
      logic [31:0] result;
   } exp_t;

   instruction_decode #(.MEM_DEPTH(256)) dut (
      .clk(clk), .rst(rst), .instruction(instruction), .reg_rs(reg_rs), .reg_rt(reg_rt),
      .opcode(opcode), .adr(adr), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
      .imm(imm), .regwrite(regwrite), .memwrite(memwrite), .memread(memread), .aluOp(aluOp),
      .immReg(immReg), .wr_reg(wr_reg), .alu_result(alu_result), .zero(zero),
      .mem_rdata(mem_rdata), .write_data(write_data)
   );

   always #5 clk = ~clk;

   // Instruction-set semantics computed directly from the operation each
   // opcode/funct names, together with the control it should raise.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [31:0] sx;
      int unsigned sh;
      logic [5:0] op, fn;
      op = ins >> 26;
      fn = ins & 32'h3F;
      sh = (ins >> 6) & 31;
      sx = $unsigned(32'($signed(16'(ins & 32'hFFFF))));
      e = '0;
      e.aluop  = 4'd0;
      e.result = a + b;
      if (op == 6'h00) begin
         e.regwrite = 1'b1;
         case (fn)
            6'h00: begin e.aluop = 4'd8;  e.result = b << sh; end
            6'h02: begin e.aluop = 4'd9;  e.result = b >> sh; end
            6'h03: begin e.aluop = 4'd10; e.result = $unsigned($signed(b) >>> sh); end
            6'h20, 6'h21: begin e.aluop = 4'd0; e.result = a + b; end
            6'h22, 6'h23: begin e.aluop = 4'd1; e.result = a - b; end
            6'h24: begin e.aluop = 4'd2; e.result = a & b; end
            6'h25: begin e.aluop = 4'd3; e.result = a | b; end
            6'h26: begin e.aluop = 4'd4; e.result = a ^ b; end
            6'h27: begin e.aluop = 4'd5; e.result = ~(a | b); end
            6'h2A: begin e.aluop = 4'd6; e.result = ($signed(a) < $signed(b)) ? 1 : 0; end
            6'h2B: begin e.aluop = 4'd7; e.result = (a < b) ? 1 : 0; end
            default: e.regwrite = 1'b0;
         endcase
      end else if (op == 6'h04) begin
         e.aluop = 4'd1; e.result = a - b;
      end else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B}) begin
         e.immreg   = 1'b1;
         e.regwrite = (op != 6'h2B);
         e.memwrite = (op == 6'h2B);
         e.memread  = (op == 6'h23);
         case (op)
            6'h0A: begin e.aluop = 4'd6;  e.result = ($signed(a) < $signed(sx)) ? 1 : 0; end
            6'h0B: begin e.aluop = 4'd7;  e.result = (a < sx) ? 1 : 0; end
            6'h0C: begin e.aluop = 4'd2;  e.result = a & sx; end
            6'h0D: begin e.aluop = 4'd3;  e.result = a | sx; end
            6'h0E: begin e.aluop = 4'd4;  e.result = a ^ sx; end
            6'h0F: begin e.aluop = 4'd11; e.result = sx * 65536; end
            default: begin e.aluop = 4'd0; e.result = a + sx; end
         endcase
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compares every output against the model for the current inputs.
   task automatic check_all(input string tag);
      exp_t e;
      logic [31:0] rd_exp;
      e = model(instruction, reg_rs, reg_rt);
      rd_exp = mdl_mem[(e.result / 4) % 256];
      chk({tag, ".opcode"}, 32'(opcode), instruction / 32'h0400_0000);
      chk({tag, ".adr"},    32'(adr),    instruction % 32'h0400_0000);
      chk({tag, ".rs"},     32'(rs),     (instruction / 32'h20_0000) % 32);
      chk({tag, ".rt"},     32'(rt),     (instruction / 32'h1_0000) % 32);
      chk({tag, ".rd"},     32'(rd),     (instruction / 32'h800) % 32);
      chk({tag, ".shamt"},  32'(shamt),  (instruction / 64) % 32);
      chk({tag, ".funct"},  32'(funct),  instruction % 64);
      chk({tag, ".imm"},    32'(imm),    instruction % 32'h1_0000);
      chk({tag, ".ctrl"}, {28'b0, regwrite, memwrite, memread, immReg},
          {28'b0, e.regwrite, e.memwrite, e.memread, e.immreg});
      chk({tag, ".aluOp"},  32'(aluOp),  32'(e.aluop));
      chk({tag, ".wr_reg"}, 32'(wr_reg), e.immreg ? (instruction / 32'h1_0000) % 32 : (instruction / 32'h800) % 32);
      chk({tag, ".result"}, alu_result,  e.result);
      chk({tag, ".zero"},   32'(zero),   (e.result == 0) ? 1 : 0);
      chk({tag, ".rdata"},  mem_rdata,   rd_exp);
      chk({tag, ".wdata"},  write_data,  e.memread ? rd_exp : e.result);
   endtask

   // Advances one edge and mirrors its effect on the shadow memory.
   task automatic tick();
      exp_t e;
      e = model(instruction, reg_rs, reg_rt);
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
      end else if (e.memwrite) begin
         mdl_mem[(e.result / 4) % 256] = reg_rt;
      end
      #1;
   endtask

   task automatic apply(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      instruction = ins;
      reg_rs = a;
      reg_rt = b;
      #1;
   endtask

   logic [5:0] op_pool [13];
   logic [5:0] fn_pool [14];

   initial begin
      op_pool = '{6'h00, 6'h00, 6'h04, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
      fn_pool = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F};
      for (int i = 0; i < 256; i++) mdl_mem[i] = 'x;

      rst = 1'b1;
      apply(32'h0, 32'h0, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      #1;

      apply({6'h23, 5'd0, 5'd1, 16'h0040}, 32'h0, 32'h0);
      chk("reset_rdata", mem_rdata, 32'h0);
      check_all("reset_lw");

      apply(32'h000A5B22, 32'h0000_0003, 32'h0000_0001);
      check_all("field_split");
      apply({6'h00, 5'd3, 5'd4, 5'd5, 5'd7, 6'h02}, 32'h0, 32'h8000_0000);
      chk("srl_aluop", 32'(aluOp), 32'd9);
      chk("srl_result", alu_result, 32'h0100_0000);
      check_all("srl");

      apply({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd7, 32'd5);
      chk("add_result", alu_result, 32'd12);
      chk("add_zero", 32'(zero), 32'd0);
      apply({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22}, 32'd99, 32'd99);
      chk("sub_zero", 32'(zero), 32'd1);

      apply({6'h08, 5'd1, 5'd9, 16'hFFFF}, 32'd10, 32'd0);
      chk("addi_result", alu_result, 32'd9);
      chk("addi_immreg", 32'(immReg), 32'd1);
      chk("addi_wr_reg", 32'(wr_reg), 32'd9);

      apply({6'h2B, 5'd0, 5'd4, 16'h0008}, 32'd0, 32'hDEADBEEF);
      check_all("sw");
      tick();
      apply({6'h23, 5'd0, 5'd4, 16'h0008}, 32'd0, 32'd0);
      chk("lw_rdata", mem_rdata, 32'hDEADBEEF);
      chk("lw_wdata", write_data, 32'hDEADBEEF);
      chk("lw_memread", 32'(memread), 32'd1);
      // Same word through an address that wraps above the array span.
      apply({6'h23, 5'd0, 5'd4, 16'h0409}, 32'd0, 32'd0);
      chk("lw_wrap", mem_rdata, 32'hDEADBEEF);

      apply({6'h2B, 5'd0, 5'd4, 16'h0010}, 32'd0, 32'h1234_5678);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      apply({6'h23, 5'd0, 5'd4, 16'h0008}, 32'd0, 32'd0);
      chk("rst_old_word", mem_rdata, 32'h0);
      apply({6'h23, 5'd0, 5'd4, 16'h0010}, 32'd0, 32'd0);
      chk("rst_blocked_write", mem_rdata, 32'h0);

      apply({6'h3F, 26'h3FF_FFFF}, 32'd5, 32'd6);
      chk("unknown_ctrl", {28'b0, regwrite, memwrite, memread, immReg}, 32'h0);
      chk("unknown_aluop", 32'(aluOp), 32'd0);
      apply({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2A}, 32'hFFFF_FFFF, 32'd1);
      chk("slt_result", alu_result, 32'd1);
      apply({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2B}, 32'hFFFF_FFFF, 32'd1);
      chk("sltu_result", alu_result, 32'd0);

      for (int n = 0; n < 400; n++) begin
         logic [31:0] ins;
         logic [5:0]  op;
         ins = $urandom;
         op  = op_pool[$urandom_range(0, 12)];
         if ($urandom_range(0, 9) == 0) op = 6'($urandom);
         ins[31:26] = op;
         if (op == 6'h00) ins[5:0] = fn_pool[$urandom_range(0, 13)];
         if (op == 6'h23 || op == 6'h2B) ins[15] = 1'b0;
         apply(ins, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 64) : $urandom, $urandom);
         check_all("rand");
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
